// File: rtl/reg_wb_arbiter_pkg.sv
// Shared configuration, arbitration source encoding and sizing helpers
// for the register-file writeback arbiter.
package reg_wb_arbiter_pkg;

  localparam int unsigned XLEN_DEF           = 32;
  localparam int unsigned XREG_ADDRWIDTH_DEF = 5;
  localparam logic        RST_N_ENABLE       = 1'b0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_LU   = 2'd3
  } wb_src_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO holding long-latency results that lost arbitration.
// Exposes every slot plus a per-slot occupancy mask for hazard tracking.
module wb_fifo
  import reg_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 37
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 push_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [W-1:0]                 head,
  output logic [DEPTH-1:0][W-1:0]      entries,
  output logic [DEPTH-1:0]             valid
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [DEPTH-1:0][W-1:0] mem;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : PW'(32'(p) + 32'd1);
  endfunction

  // Pointers and occupancy; count alone encodes full/empty
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_N_ENABLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head    = mem[rd_ptr];
  assign entries = mem;

  // A slot is live when its distance from the read pointer is below count
  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid[i] = ((i + DEPTH - 32'(rd_ptr)) % DEPTH) < 32'(count);
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Drives the register-file write port from the pipeline (priority) and a
// long-latency unit, buffering LU results and exporting a pending mask.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned AW         = XREG_ADDRWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pipe_valid,
  input  logic [AW-1:0]     i_pipe_addr,
  input  logic [XLEN-1:0]   i_pipe_data,
  input  logic              i_lu_valid,
  output logic              o_lu_ready,
  input  logic [AW-1:0]     i_lu_addr,
  input  logic [XLEN-1:0]   i_lu_data,
  output logic              o_write_flag,
  output logic [AW-1:0]     o_write_addr,
  output logic [XLEN-1:0]   o_write_data,
  output logic [2**AW-1:0]  o_pending
);

  localparam int unsigned EW = AW + XLEN;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [CW-1:0]                count;
  logic [EW-1:0]                head;
  logic [FIFO_DEPTH-1:0][EW-1:0] entries;
  logic [FIFO_DEPTH-1:0]        valid;
  wb_src_e                      src;
  logic                         lu_fire;
  logic                         pipe_req;
  logic                         lu_req;
  logic                         push;
  logic                         pop;

  assign o_lu_ready = 32'(count) < FIFO_DEPTH;
  assign lu_fire    = i_lu_valid & o_lu_ready;
  assign pipe_req   = i_pipe_valid & (i_pipe_addr != '0);
  assign lu_req     = lu_fire & (i_lu_addr != '0);

  // Priority: pipeline, then FIFO head, then LU fall-through
  always_comb begin
    src = SRC_NONE;
    if (pipe_req)          src = SRC_PIPE;
    else if (count != '0)  src = SRC_FIFO;
    else if (lu_req)       src = SRC_LU;
  end

  assign pop  = (src == SRC_FIFO);
  assign push = lu_req & (src != SRC_LU);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data ({i_lu_addr, i_lu_data}),
    .count     (count),
    .head      (head),
    .entries   (entries),
    .valid     (valid)
  );

  // Output register; address/data hold when no write is issued
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_N_ENABLE) begin
      o_write_flag <= 1'b0;
      o_write_addr <= '0;
      o_write_data <= '0;
    end else begin
      o_write_flag <= (src != SRC_NONE);
      case (src)
        SRC_PIPE: begin
          o_write_addr <= i_pipe_addr;
          o_write_data <= i_pipe_data;
        end
        SRC_FIFO: begin
          o_write_addr <= head[EW-1 -: AW];
          o_write_data <= head[XLEN-1:0];
        end
        SRC_LU: begin
          o_write_addr <= i_lu_addr;
          o_write_data <= i_lu_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_pending = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (valid[i]) o_pending[entries[i][EW-1 -: AW]] = 1'b1;
    end
    if (o_write_flag) o_pending[o_write_addr] = 1'b1;
    o_pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: expected writes are queued in order,
// a negedge monitor pops them as the write port fires.
module tb_reg_wb_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pipe_valid;
  logic [AW-1:0]     pipe_addr;
  logic [XLEN-1:0]   pipe_data;
  logic              lu_valid;
  logic              lu_ready;
  logic [AW-1:0]     lu_addr;
  logic [XLEN-1:0]   lu_data;
  logic              wr_flag;
  logic [AW-1:0]     wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic [2**AW-1:0]  pending;

  typedef struct packed {
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
  } wr_t;

  wr_t sb[$];
  wr_t exp_w;
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter #(
    .FIFO_DEPTH (DEPTH),
    .XLEN       (XLEN),
    .AW         (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst_n),
    .i_pipe_valid (pipe_valid),
    .i_pipe_addr  (pipe_addr),
    .i_pipe_data  (pipe_data),
    .i_lu_valid   (lu_valid),
    .o_lu_ready   (lu_ready),
    .i_lu_addr    (lu_addr),
    .i_lu_data    (lu_data),
    .o_write_flag (wr_flag),
    .o_write_addr (wr_addr),
    .o_write_data (wr_data),
    .o_pending    (pending)
  );

  // Every write must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_flag === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", wr_addr, wr_data);
      end else begin
        exp_w = sb.pop_front();
        if (wr_addr !== exp_w.a || wr_data !== exp_w.d) begin
          errors++;
          $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                   wr_addr, wr_data, exp_w.a, exp_w.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic idle();
    pipe_valid = 1'b0; pipe_addr = '0; pipe_data = '0;
    lu_valid   = 1'b0; lu_addr   = '0; lu_data   = '0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d writes still outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    checks++; if (wr_flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b required 0", wr_flag); end
    checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d required 0", wr_addr); end
    checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_data: got %h required 0", wr_data); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", lu_ready); end
    checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending: got %h required 0", pending); end
    rst_n = 1'b1;
  endtask

  task automatic test_pipe_basic();
    @(negedge clk);
    pipe_valid = 1'b1; pipe_addr = 5'd5; pipe_data = 32'h1234;
    sb.push_back('{a: 5'd5, d: 32'h1234});
    @(negedge clk);
    checks++; if (wr_flag !== 1'b1) begin errors++; $display("FAIL pipe_flag: got %b required 1", wr_flag); end
    checks++; if (pending !== 32'h20) begin errors++; $display("FAIL pipe_pending: got %h required 00000020", pending); end
    idle();
    @(negedge clk);
    checks++; if (wr_flag !== 1'b0) begin errors++; $display("FAIL pipe_flag_clear: got %b required 0", wr_flag); end
    checks++; if (pending !== '0) begin errors++; $display("FAIL pipe_pending_clear: got %h required 0", pending); end
    drain("pipe");
  endtask

  task automatic test_fall_through();
    @(negedge clk);
    lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'hAAAA;
    sb.push_back('{a: 5'd7, d: 32'hAAAA});
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL ft_ready_pre: got %b required 1", lu_ready); end
    @(negedge clk);
    idle();
    checks++; if (wr_flag !== 1'b1) begin errors++; $display("FAIL ft_flag: got %b required 1", wr_flag); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL ft_ready_post: got %b required 1", lu_ready); end
    checks++; if (pending !== 32'h80) begin errors++; $display("FAIL ft_pending: got %h required 00000080", pending); end
    drain("fall_through");
  endtask

  task automatic test_back_to_back();
    int unsigned   pa[7] = '{1, 2, 3, 4, 0, 0, 0};
    bit            er[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [AW-1:0] lq[$];
    bit            offered = 1'b0;
    bit            acc     = 1'b0;
    lq.push_back(5'd8); lq.push_back(5'd9); lq.push_back(5'd10);
    for (int unsigned k = 1; k <= 4; k++) sb.push_back('{a: AW'(k), d: XLEN'(32'h100 + k)});
    for (int unsigned k = 8; k <= 10; k++) sb.push_back('{a: AW'(k), d: XLEN'(32'h200 + k)});
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (offered && acc) void'(lq.pop_front());
      pipe_valid = (pa[i] != 0);
      pipe_addr  = AW'(pa[i]);
      pipe_data  = XLEN'(32'h100 + pa[i]);
      if (lq.size() != 0) begin
        lu_valid = 1'b1; lu_addr = lq[0]; lu_data = XLEN'(32'h200 + 32'(lq[0]));
      end else begin
        lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
      end
      checks++;
      if (lu_ready !== er[i]) begin
        errors++;
        $display("FAIL b2b_ready_cycle%0d: got %b required %b", i, lu_ready, er[i]);
      end
      offered = lu_valid;
      acc     = lu_ready;
    end
    @(negedge clk);
    if (offered && acc) void'(lq.pop_front());
    idle();
    checks++;
    if (lq.size() != 0) begin
      errors++;
      $display("FAIL b2b_accept: %0d LU results not accepted, required 0", lq.size());
    end
    drain("back_to_back");
  endtask

  task automatic test_zero_addr();
    @(negedge clk);
    pipe_valid = 1'b1; pipe_addr = '0; pipe_data = 32'hDEAD;
    lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 32'h55;
    sb.push_back('{a: 5'd3, d: 32'h55});
    @(negedge clk);
    idle();
    checks++; if (wr_flag !== 1'b1) begin errors++; $display("FAIL zero_pipe_flag: got %b required 1", wr_flag); end
    checks++; if (pending !== 32'h8) begin errors++; $display("FAIL zero_pipe_pending: got %h required 00000008", pending); end
    drain("zero_pipe");
    @(negedge clk);
    lu_valid = 1'b1; lu_addr = '0; lu_data = 32'h77;
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL zero_lu_ready: got %b required 1", lu_ready); end
    @(negedge clk);
    idle();
    checks++; if (wr_flag !== 1'b0) begin errors++; $display("FAIL zero_lu_flag: got %b required 0", wr_flag); end
    checks++; if (pending !== '0) begin errors++; $display("FAIL zero_lu_pending: got %h required 0", pending); end
    @(negedge clk);
    checks++; if (wr_flag !== 1'b0) begin errors++; $display("FAIL zero_lu_nobuf: got %b required 0", wr_flag); end
  endtask

  task automatic test_push_pop();
    sb.push_back('{a: 5'd20, d: 32'h120});
    sb.push_back('{a: 5'd11, d: 32'h211});
    sb.push_back('{a: 5'd12, d: 32'h212});
    @(negedge clk);
    pipe_valid = 1'b1; pipe_addr = 5'd20; pipe_data = 32'h120;
    lu_valid = 1'b1; lu_addr = 5'd11; lu_data = 32'h211;
    @(negedge clk);
    pipe_valid = 1'b0; pipe_addr = '0; pipe_data = '0;
    lu_valid = 1'b1; lu_addr = 5'd12; lu_data = 32'h212;
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL pp_ready: got %b required 1", lu_ready); end
    checks++; if (pending !== 32'h0010_0800) begin errors++; $display("FAIL pp_pending_a: got %h required 00100800", pending); end
    @(negedge clk);
    idle();
    checks++; if (pending !== 32'h1800) begin errors++; $display("FAIL pp_pending_b: got %h required 00001800", pending); end
    @(negedge clk);
    checks++; if (pending !== 32'h1000) begin errors++; $display("FAIL pp_pending_c: got %h required 00001000", pending); end
    drain("push_pop");
  endtask

  task automatic test_async_reset();
    sb.push_back('{a: 5'd1, d: 32'h301});
    sb.push_back('{a: 5'd2, d: 32'h302});
    sb.push_back('{a: 5'd3, d: 32'h303});
    @(negedge clk);
    pipe_valid = 1'b1; pipe_addr = 5'd1; pipe_data = 32'h301;
    lu_valid = 1'b1; lu_addr = 5'd13; lu_data = 32'h413;
    @(negedge clk);
    pipe_addr = 5'd2; pipe_data = 32'h302;
    lu_addr = 5'd14; lu_data = 32'h414;
    @(negedge clk);
    pipe_addr = 5'd3; pipe_data = 32'h303;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL ar_full_ready: got %b required 0", lu_ready); end
    @(negedge clk);
    checks++; if (pending !== 32'h6008) begin errors++; $display("FAIL ar_pending_full: got %h required 00006008", pending); end
    pipe_addr = 5'd4; pipe_data = 32'h304;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wr_flag !== 1'b0) begin errors++; $display("FAIL ar_flag: got %b required 0", wr_flag); end
    checks++; if (wr_addr !== '0 || wr_data !== '0) begin errors++; $display("FAIL ar_addr_data: got %0d/%h required 0/0", wr_addr, wr_data); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: got %b required 1", lu_ready); end
    checks++; if (pending !== '0) begin errors++; $display("FAIL ar_pending: got %h required 0", pending); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL ar_pre_writes: %0d outstanding, required 0", sb.size()); end
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (wr_flag !== 1'b0) begin errors++; $display("FAIL ar_post_flag: got %b required 0", wr_flag); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL ar_post_ready: got %b required 1", lu_ready); end
  endtask

  initial begin
    test_reset();
    test_pipe_basic();
    test_fall_through();
    test_back_to_back();
    test_zero_addr();
    test_push_pop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Writeback arbiter that sits directly upstream of the general register file and drives its single write port. It merges two result sources: the in-order pipeline writeback, which always has priority, and a long-latency unit (divider / load-miss return) behind a valid/ready handshake. Long-latency results that lose arbitration are held in a small FIFO. A pending-register mask is exported so issue logic can stall on RAW/WAW hazards against buffered results.

## Interface
- `FIFO_DEPTH`, default 2: long-latency buffer entries; must be ≥1.
- `XLEN`, default `` `XLEN `` (32): data width.
- `AW`, default `` `XREG_ADDRWIDTH `` (5): register address width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `i_pipe_valid`  in  1: pipeline result valid this cycle; never stalled.
- `i_pipe_addr`  in  AW: pipeline destination register.
- `i_pipe_data`  in  XLEN: pipeline result.
- `i_lu_valid`  in  1: long-latency result offered.
- `o_lu_ready`  out  1: arbiter can accept a long-latency result.
- `i_lu_addr`  in  AW: long-latency destination register.
- `i_lu_data`  in  XLEN: long-latency result.
- `o_write_flag`  out  1: register-file write enable, registered.
- `o_write_addr`  out  AW: register-file write address, registered.
- `o_write_data`  out  XLEN: register-file write data, registered.
- `o_pending`  out  2^AW: bit r set while a result for xr is buffered or in the output register.

## Operation
- Accept: an LU transfer happens when `i_lu_valid & o_lu_ready`.
- `o_lu_ready` = (count < FIFO_DEPTH). It is combinational from count only, with no dependence on `i_lu_valid`.
- Effective pipe request: `i_pipe_valid & (i_pipe_addr != 0)`.
- Effective LU request: accepted transfer with `i_lu_addr != 0`. Accepted x0 transfers are consumed and discarded: never written, never buffered.
- Per-cycle priority for the output register:
  1. Pipeline wins whenever it requests.
  2. Otherwise FIFO head, if count > 0; pop it.
  3. Otherwise an accepted LU transfer passes straight through (fall-through, no FIFO entry).
  4. Otherwise `o_write_flag` <= 0, and addr/data hold their previous values.
- Push: an accepted non-x0 LU transfer that did not win slot 3 is pushed at the tail.
  - Push and pop in the same cycle are legal. Count is unchanged and order is preserved.
- FIFO: circular, with read/write pointers wrapping modulo FIFO_DEPTH and a count of 0..FIFO_DEPTH. Strict FIFO order among LU results.
- No reordering between sources. Issue logic guarantees no two in-flight writes target the same register, using `o_pending`. The block does not check this.
- `o_pending`: OR of one-hot(addr) over valid FIFO entries, plus one-hot(`o_write_addr`) when `o_write_flag`=1. Bit 0 is always 0. Combinational from registered state only.

## Timing
- Reset (`rst`=0, async): `o_write_flag`=0, `o_write_addr`=0, `o_write_data`=0, count=0, pointers=0.
  - As a consequence, `o_lu_ready`=1 and `o_pending`=0 during reset.
  - Reset mid-operation discards all buffered results; no write is issued for them.
- Latency:
  - Pipe result: presented in cycle N, appears on `o_write_*` in cycle N+1; the register file commits on the edge ending N+1.
  - LU fall-through: 1 cycle.
  - Buffered LU entry: 1 cycle after the first cycle with no pipe request and it at the head.
- Full: count = FIFO_DEPTH puts `o_lu_ready`=0 the same cycle. It rises the cycle after the first pop.
- Starvation is permitted: continuous pipe requests hold the FIFO indefinitely.
- Throughput: one register-file write per cycle maximum.

## Structure
- `` `XLEN ``, `` `XREG_ADDRWIDTH ``, and the reset/write-enable level macros come from the shared `config.v`. Add `` `RST_N_ENABLE `` (1'b0) there for the active-low reset.
- One natural sub-module: `wb_fifo`, a parameterised synchronous FIFO. It has push/pop, count, and head outputs and no full/empty registers beyond count.
- The top level holds the arbitration mux, the output register, and the pending-mask decode.

## Test plan
- Reset, then pipe write x5=0x1234 in cycle 1 → cycle 2: `o_write_flag`=1, addr=5, data=0x1234; cycle 3: flag=0. During cycle 2, `o_pending`[5]=1.
- LU x7=0xAAAA with pipe idle → fall-through: write in the next cycle, count stays 0, ready stays 1.
- Pipe valid 4 consecutive cycles (x1..x4) while LU offers x8, x9, x10 back-to-back → x8 and x9 are accepted, then ready=0 (count=2) and x10 is held. Writes occur in order x1, x2, x3, x4, x8, x9, x10. Ready returns 1 one cycle after x8 pops.
- Pipe addr=0 valid with LU x3=0x55 → the pipe is ignored and x3 takes the port via fall-through. Separately, LU addr=0 → accepted, no write, count unchanged.
- Simultaneous push and pop (count=1, pipe idle, LU x12 offered) → head writes, x12 enters the FIFO, count remains 1.
- Assert `rst` low asynchronously with count=2 between clock edges → outputs clear immediately, and no buffered write appears after reset release.
